// File: rtl/hilo_muldiv_unit.sv
// HI/LO product register with an iterative shift-add multiplier and restoring divider.
// Results land in Qhi/Qlo only at the end of an operation; MTHI/MTLO-style direct loads use D.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2*WIDTH-1:0] D,
    input  logic               ld_hi,
    input  logic               ld_lo,
    output logic [WIDTH-1:0]   Qhi,
    output logic [WIDTH-1:0]   Qlo,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, dbz_pend;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd, sh, raw_a;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic n, input logic [WIDTH-1:0] x);
        return n ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic n, input logic [2*WIDTH-1:0] x);
        return n ? -x : x;
    endfunction

    logic             accept, b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign accept = (state == IDLE) && start;
    assign b_zero = (B == '0);
    assign a_neg  = ~op[0] & A[WIDTH-1];
    assign b_neg  = ~op[0] & B[WIDTH-1];
    assign abs_a  = cond_neg_w(a_neg, A);
    assign abs_b  = cond_neg_w(b_neg, B);

    // Iteration datapath: MUL keeps |A| in opnd and shifts |B| right; DIV keeps |B| and shifts |A| left.
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nxt;

    assign mul_addend = sh[0] ? opnd : '0;
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign div_trial  = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
    assign div_ge     = (div_trial >= {1'b0, opnd});
    assign rem_nxt    = div_ge ? (div_trial[WIDTH-1:0] - opnd) : div_trial[WIDTH-1:0];

    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        prod   = cond_neg_2w(neg_q, acc);
        if (dbz_pend) begin
            res_hi = raw_a;
            res_lo = '1;
        end else if (is_div) begin
            res_hi = cond_neg_w(neg_r, acc[2*WIDTH-1:WIDTH]);
            res_lo = cond_neg_w(neg_q, acc[WIDTH-1:0]);
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (op[1] && b_zero) ? FIX : RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers carry no reset; they are always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            opnd  <= op[1] ? abs_b : abs_a;
            sh    <= op[1] ? abs_a : abs_b;
            acc   <= '0;
            raw_a <= A;
        end else if (state == RUN) begin
            if (is_div) begin
                acc <= {rem_nxt, acc[WIDTH-2:0], div_ge};
                sh  <= {sh[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
                sh  <= {1'b0, sh[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz_pend    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            Qhi         <= '0;
            Qlo         <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            busy  <= accept || (state != IDLE);
            if (accept) begin
                is_div   <= op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= op[1] & a_neg;
                dbz_pend <= op[1] & b_zero;
                cnt      <= CW'(WIDTH);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end
            if (state == FIX) begin
                done        <= 1'b1;
                div_by_zero <= dbz_pend;
                Qhi         <= res_hi;
                Qlo         <= res_lo;
            end else if (state == IDLE && !start) begin
                if (ld_hi) Qhi <= D[2*WIDTH-1:WIDTH];
                if (ld_lo) Qlo <= D[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit (WIDTH=32): loads, MUL/DIV results,
// latency, divide-by-zero, busy/ignore rules, back-to-back start and abort by clr.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr, start, ld_hi, ld_lo;
    logic [1:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] d;
    logic [W-1:0]   qhi, qlo;
    logic           busy, done, dbz;

    int vectors     = 0;
    int miscompares = 0;
    int seen_done;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .A(a), .B(b), .D(d),
        .ld_hi(ld_hi), .ld_lo(ld_lo), .Qhi(qhi), .Qlo(qlo),
        .busy(busy), .done(done), .div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation so that it is sampled on the next rising edge, then scramble inputs.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 2'b11; a = 32'h5A5A_A5A5; b = '0;
    endtask

    task automatic wait_done(input string tag, input int already, input int exp_lat,
                             input logic [63:0] exp_q, input logic exp_dbz);
        int n;
        n = already;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 200);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_q"}, {qhi, qlo}, exp_q);
        check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
    endtask

    task automatic end_pulse(input string tag, input logic [63:0] exp_q, input logic exp_dbz);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check({tag, "_q_hold"}, {qhi, qlo}, exp_q);
        check({tag, "_dbz_hold"}, 64'(dbz), 64'(exp_dbz));
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; ld_hi = 1'b0; ld_lo = 1'b0;
        op = '0; a = '0; b = '0; d = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", {qhi, qlo}, 64'd0);
        check("rst_ctl", {61'd0, busy, done, dbz}, 64'd0);
        @(negedge clk) clr = 1'b0;

        @(negedge clk);
        d = 64'h0000_0001_0000_0002; ld_hi = 1'b1; ld_lo = 1'b1;
        @(posedge clk); #1;
        ld_hi = 1'b0; ld_lo = 1'b0;
        check("ld_both", {qhi, qlo}, 64'h0000_0001_0000_0002);

        @(negedge clk);
        d = 64'hAAAA_AAAA_0000_00FF; ld_lo = 1'b1;
        @(posedge clk); #1;
        ld_lo = 1'b0;
        check("ld_lo_only", {qhi, qlo}, 64'h0000_0001_0000_00FF);

        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_mid_q", {qhi, qlo}, 64'd0);
        check("clr_mid_ctl", {62'd0, busy, done}, 64'd0);
        @(negedge clk) clr = 1'b0;

        @(negedge clk) issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done("smul", 0, 33, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        end_pulse("smul", 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);

        @(negedge clk) issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("umul", 0, 33, 64'hFFFF_FFFE_0000_0001, 1'b0);

        @(negedge clk) issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done("smul_min", 0, 33, 64'h4000_0000_0000_0000, 1'b0);

        @(negedge clk) issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("sdiv_neg_a", 0, 33, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);

        @(negedge clk) issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done("sdiv_neg_b", 0, 33, 64'h0000_0001_FFFF_FFFD, 1'b0);

        @(negedge clk) issue(2'b11, 32'h0000_1234, 32'd0);
        wait_done("dbz", 0, 1, 64'h0000_1234_FFFF_FFFF, 1'b1);
        end_pulse("dbz", 64'h0000_1234_FFFF_FFFF, 1'b1);

        @(negedge clk) issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("sdiv_min", 0, 33, 64'h0000_0000_8000_0000, 1'b0);

        @(negedge clk) issue(2'b11, 32'd100, 32'd7);
        wait_done("udiv", 0, 33, 64'h0000_0002_0000_000E, 1'b0);

        // Start and ld_hi during a MUL must both be ignored.
        @(negedge clk) issue(2'b00, 32'd5, 32'd6);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        ld_hi = 1'b1; d = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk); #1;
        start = 1'b0; ld_hi = 1'b0;
        check("busy_mid", 64'(busy), 64'd1);
        wait_done("busy_ign", 3, 33, 64'h0000_0000_0000_001E, 1'b0);

        // Start on the edge that ends the done cycle.
        issue(2'b01, 32'h0001_0000, 32'h0001_0000);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b", 0, 33, 64'h0000_0001_0000_0000, 1'b0);
        end_pulse("b2b", 64'h0000_0001_0000_0000, 1'b0);

        @(negedge clk) issue(2'b10, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3 clr = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_q", {qhi, qlo}, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk) clr = 1'b0;
        seen_done = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_idle", {qhi, qlo, 63'd0, busy}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
